// File: rtl/branch_datapath.sv
// Single-bus 32-bit datapath slice for the conditional-branch sequence (T0-T6):
// PC/MAR/MDR/IR/Y/Z, 16-entry register file, ADD/INC ALU, Cout immediate and CON.
module gp_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clock or posedge clear)
    if (clear)   q <= '0;
    else if (ld) q <= d;
endmodule

module branch_datapath #(
  parameter int WIDTH = 32,
  parameter int NREGS = 16
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             PCout,
  input  logic             Zlowout,
  input  logic             Zhighout,
  input  logic             MDRout,
  input  logic             Rout,
  input  logic             Cout,
  input  logic             BAout,
  input  logic             PCin,
  input  logic             MARin,
  input  logic             MDRin,
  input  logic             IRin,
  input  logic             Yin,
  input  logic             Zlowin,
  input  logic             Zhighin,
  input  logic             Rin,
  input  logic             con_in,
  input  logic             BrPCin,
  input  logic             Gra,
  input  logic             Grb,
  input  logic             Grc,
  input  logic             IncPC,
  input  logic             ADD,
  input  logic             Read,
  input  logic [WIDTH-1:0] Mdatain,
  output logic [WIDTH-1:0] bus_out,
  output logic [WIDTH-1:0] pc_out,
  output logic [WIDTH-1:0] mar_out,
  output logic [WIDTH-1:0] ir_out,
  output logic [WIDTH-1:0] zlo_out,
  output logic [WIDTH-1:0] zhi_out,
  output logic             con_out
);
  localparam int RW = $clog2(NREGS);

  logic [WIDTH-1:0] pc, mar, mdr, ir, y, zlo, zhi;
  logic             con;
  logic [NREGS-1:0][WIDTH-1:0] rf;
  logic [RW-1:0]    sel;
  logic [WIDTH-1:0] bus, c_sext;
  logic [WIDTH:0]   sum;
  logic             cond;

  always_comb begin
    sel = '0;
    if (Gra)      sel = ir[23 +: RW];
    else if (Grb) sel = ir[19 +: RW];
    else if (Grc) sel = ir[15 +: RW];
  end

  assign c_sext = {{(WIDTH-19){ir[18]}}, ir[18:0]};

  // BAout shares the register-file driver slot but reads R0 as constant 0
  always_comb begin
    bus = '0;
    if (clear)              bus = '0;
    else if (PCout)         bus = pc;
    else if (Zlowout)       bus = zlo;
    else if (Zhighout)      bus = zhi;
    else if (MDRout)        bus = mdr;
    else if (Rout || BAout) bus = (BAout && sel == '0) ? '0 : rf[sel];
    else if (Cout)          bus = c_sext;
  end

  always_comb begin
    sum = '0;
    if (IncPC)    sum = {1'b0, bus} + {{WIDTH{1'b0}}, 1'b1};
    else if (ADD) sum = {1'b0, y} + {1'b0, bus};
  end

  always_comb begin
    cond = 1'b0;
    case (ir[20:19])
      2'b00: cond = (bus == '0);
      2'b01: cond = (bus != '0);
      2'b10: cond = ~bus[WIDTH-1];
      2'b11: cond = bus[WIDTH-1];
      default: cond = 1'b0;
    endcase
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      pc  <= '0;
      mar <= '0;
      mdr <= '0;
      ir  <= '0;
      y   <= '0;
      zlo <= '0;
      zhi <= '0;
      con <= 1'b0;
    end else begin
      // BrPCin sees the pre-edge CON even when con_in fires on the same edge
      if (PCin)               pc <= bus;
      else if (BrPCin && con) pc <= bus;
      if (MARin)   mar <= bus;
      if (MDRin)   mdr <= Read ? Mdatain : bus;
      if (IRin)    ir  <= bus;
      if (Yin)     y   <= bus;
      if (Zlowin)  zlo <= sum[WIDTH-1:0];
      if (Zhighin) zhi <= {{(WIDTH-1){1'b0}}, sum[WIDTH]};
      if (con_in)  con <= cond;
    end
  end

  for (genvar i = 0; i < NREGS; i++) begin : g_rf
    gp_reg #(.WIDTH(WIDTH)) u_r (
      .clock (clock),
      .clear (clear),
      .ld    (Rin && sel == RW'(i)),
      .d     (bus),
      .q     (rf[i])
    );
  end

  assign bus_out = bus;
  assign pc_out  = pc;
  assign mar_out = mar;
  assign ir_out  = ir;
  assign zlo_out = zlo;
  assign zhi_out = zhi;
  assign con_out = con;
endmodule

// File: tb/tb_branch_datapath.sv
// Bench for branch_datapath: directed branch sequences plus random control vectors,
// all checked every cycle against an architectural model of the datapath.
module tb_branch_datapath;
  typedef struct packed {
    logic pcout, zlowout, zhighout, mdrout, rout, cout, baout;
    logic pcin, marin, mdrin, irin, yin, zlowin, zhighin, rin, con_in, brpcin;
    logic gra, grb, grc, incpc, add, read;
  } ctrl_t;

  localparam ctrl_t IDLE  = '0;
  localparam ctrl_t T0    = '{pcout:1, marin:1, incpc:1, zlowin:1, default:0};
  localparam ctrl_t T1    = '{zlowout:1, pcin:1, read:1, mdrin:1, default:0};
  localparam ctrl_t T2    = '{mdrout:1, irin:1, default:0};
  localparam ctrl_t T3    = '{gra:1, rout:1, con_in:1, default:0};
  localparam ctrl_t T4    = '{pcout:1, yin:1, default:0};
  localparam ctrl_t T5    = '{cout:1, add:1, zlowin:1, zhighin:1, default:0};
  localparam ctrl_t T6    = '{zlowout:1, brpcin:1, default:0};
  localparam ctrl_t LDMDR = '{read:1, mdrin:1, default:0};
  localparam ctrl_t MD2IR = '{mdrout:1, irin:1, default:0};
  localparam ctrl_t MD2RA = '{mdrout:1, gra:1, rin:1, default:0};
  localparam ctrl_t MD2PC = '{mdrout:1, pcin:1, default:0};

  logic        clock = 0, clear = 1;
  ctrl_t       c = '0;
  logic [31:0] mdata = '0;
  logic [31:0] bus_out, pc_out, mar_out, ir_out, zlo_out, zhi_out;
  logic        con_out;
  int          nchk = 0, nfail = 0;

  // architectural state of the model
  logic [31:0] m_pc, m_mar, m_mdr, m_ir, m_y, m_zlo, m_zhi;
  logic        m_con;
  logic [31:0] m_r [16];

  always #10 clock = ~clock;

  branch_datapath dut (
    .clock(clock), .clear(clear),
    .PCout(c.pcout), .Zlowout(c.zlowout), .Zhighout(c.zhighout), .MDRout(c.mdrout),
    .Rout(c.rout), .Cout(c.cout), .BAout(c.baout),
    .PCin(c.pcin), .MARin(c.marin), .MDRin(c.mdrin), .IRin(c.irin), .Yin(c.yin),
    .Zlowin(c.zlowin), .Zhighin(c.zhighin), .Rin(c.rin), .con_in(c.con_in), .BrPCin(c.brpcin),
    .Gra(c.gra), .Grb(c.grb), .Grc(c.grc), .IncPC(c.incpc), .ADD(c.add), .Read(c.read),
    .Mdatain(mdata),
    .bus_out(bus_out), .pc_out(pc_out), .mar_out(mar_out), .ir_out(ir_out),
    .zlo_out(zlo_out), .zhi_out(zhi_out), .con_out(con_out)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_pc = 0; m_mar = 0; m_mdr = 0; m_ir = 0; m_y = 0; m_zlo = 0; m_zhi = 0; m_con = 0;
    for (int i = 0; i < 16; i++) m_r[i] = 0;
  endtask

  function automatic logic [3:0] m_sel(input ctrl_t k);
    if (k.gra) return m_ir[26:23];
    if (k.grb) return m_ir[22:19];
    if (k.grc) return m_ir[18:15];
    return 4'd0;
  endfunction

  function automatic logic [31:0] m_bus(input ctrl_t k);
    logic [3:0] s;
    s = m_sel(k);
    if (k.pcout)    return m_pc;
    if (k.zlowout)  return m_zlo;
    if (k.zhighout) return m_zhi;
    if (k.mdrout)   return m_mdr;
    if (k.rout || k.baout) return (k.baout && s == 0) ? 32'd0 : m_r[s];
    if (k.cout)     return 32'($signed(m_ir[18:0]));
    return 32'd0;
  endfunction

  task automatic m_update(input ctrl_t k, input logic [31:0] md);
    logic [31:0] b;
    longint unsigned s;
    logic cond;
    b = m_bus(k);
    s = k.incpc ? longint'(b) + 1 : k.add ? longint'(m_y) + longint'(b) : 0;
    case (m_ir[20:19])
      2'b00: cond = (b == 0);
      2'b01: cond = (b != 0);
      2'b10: cond = !b[31];
      default: cond = b[31];
    endcase
    if (k.pcin || (k.brpcin && m_con)) m_pc = b;
    if (k.con_in)  m_con = cond;
    if (k.marin)   m_mar = b;
    if (k.mdrin)   m_mdr = k.read ? md : b;
    if (k.irin)    m_ir  = b;
    if (k.yin)     m_y   = b;
    if (k.zlowin)  m_zlo = s[31:0];
    if (k.zhighin) m_zhi = {31'd0, s[32]};
    if (k.rin)     m_r[m_sel(k)] = b;
  endtask

  task automatic check_state(input ctrl_t k);
    check("bus", bus_out, m_bus(k));
    check("pc",  pc_out,  m_pc);
    check("mar", mar_out, m_mar);
    check("ir",  ir_out,  m_ir);
    check("zlo", zlo_out, m_zlo);
    check("zhi", zhi_out, m_zhi);
    check("con", {31'd0, con_out}, {31'd0, m_con});
  endtask

  // one clock cycle: drive, compare on the falling edge, advance model, step past rising edge
  task automatic step(input ctrl_t k, input logic [31:0] md);
    c = k; mdata = md;
    @(negedge clock);
    check_state(k);
    m_update(k, md);
    @(posedge clock); #1;
  endtask

  task automatic check_zero();
    check("clr_bus", bus_out, 0); check("clr_pc", pc_out, 0); check("clr_mar", mar_out, 0);
    check("clr_ir", ir_out, 0);   check("clr_zlo", zlo_out, 0); check("clr_zhi", zhi_out, 0);
    check("clr_con", {31'd0, con_out}, 0);
  endtask

  task automatic clear_pulse(input ctrl_t k);
    c = k; #1 clear = 1; #1;
    check_zero();
    m_reset();
    clear = 0; #1;
    step(IDLE, 0);
  endtask

  task automatic peek(input ctrl_t k, input string name, input logic [31:0] exp);
    c = k; #1;
    check(name, bus_out, exp);
    check({name, "_m"}, m_bus(k), exp);
  endtask

  task automatic preload(input logic [31:0] instr, input logic [31:0] rval, input logic [31:0] pc0);
    step(LDMDR, instr); step(MD2IR, 0);
    step(LDMDR, rval);  step(MD2RA, 0);
    step(LDMDR, pc0);   step(MD2PC, 0);
  endtask

  task automatic run_branch(input logic [31:0] instr, input logic [31:0] rval, input logic [31:0] pc0);
    preload(instr, rval, pc0);
    step(T0, 0); step(T1, instr); step(T2, 0); step(T3, 0);
    step(T4, 0); step(T5, 0); step(T6, 0);
  endtask

  initial begin
    ctrl_t k;
    m_reset();
    repeat (2) @(posedge clock);
    #1 check_zero();
    clear = 0;

    run_branch(32'h91200023, 32'd0, 32'd4);
    check("brzr_ir", ir_out, 32'h91200023);
    check("brzr_con", {31'd0, con_out}, 1);
    check("brzr_pc", pc_out, 32'd40);

    run_branch(32'h91200023, 32'd5, 32'd4);
    check("brzr_nt_con", {31'd0, con_out}, 0);
    check("brzr_nt_pc", pc_out, 32'd5);

    run_branch(32'h91380023, 32'h80000000, 32'd5);
    check("brmi_con", {31'd0, con_out}, 1);
    check("brmi_pc", pc_out, 32'd41);

    run_branch(32'h91300023, 32'h80000000, 32'd4);
    check("brpl_con", {31'd0, con_out}, 0);
    check("brpl_pc", pc_out, 32'd5);

    run_branch(32'h912FFFFD, 32'd7, 32'd10);
    check("brnz_con", {31'd0, con_out}, 1);
    check("brnz_pc", pc_out, 32'd8);
    check("brnz_zhi", zhi_out, 32'd1);
    peek('{cout:1, default:0}, "cout_neg", 32'hFFFFFFFD);
    step(IDLE, 0);

    step(LDMDR, 32'd12); step(MD2PC, 0); step(LDMDR, 32'd99);
    peek('{pcout:1, mdrout:1, default:0}, "prio_pc_mdr", 32'd12);
    peek(IDLE, "bus_idle", 32'd0);
    step(IDLE, 0);
    step(LDMDR, 32'd0); step(MD2IR, 0); step(LDMDR, 32'd7); step(MD2RA, 0);
    peek('{baout:1, gra:1, default:0}, "baout_r0", 32'd0);
    peek('{rout:1, gra:1, default:0}, "rout_r0", 32'd7);
    step(IDLE, 0);

    // clear lands in T5 of a taken branch; refetch must start from PC = 0
    preload(32'h91200023, 32'd0, 32'd4);
    step(T0, 0); step(T1, 32'h91200023); step(T2, 0); step(T3, 0); step(T4, 0);
    clear_pulse(T5);
    step(T0, 0);
    check("refetch_mar", mar_out, 32'd0);
    step(T1, 32'h91200023);
    check("refetch_pc", pc_out, 32'd1);
    step(T2, 0);
    check("refetch_ir", ir_out, 32'h91200023);

    for (int n = 0; n < 600; n++) begin
      k = ctrl_t'(23'($urandom) & 23'($urandom) & 23'($urandom));
      if ($urandom_range(0, 59) == 0) clear_pulse(k);
      else step(k, $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
